// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and table-entry type for the Huffman codec.
package huffman_pkg;

    localparam int unsigned SYM_W       = 8;   // symbol width
    localparam int unsigned LEN_W       = 4;   // code-length field width
    localparam int unsigned MAX_LEN     = 8;   // longest legal code, also code field width
    localparam int unsigned DEF_ENTRIES = 32;  // default table capacity

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // One code-table entry, shared with the encoder.
    typedef struct packed {
        logic               valid;
        logic [SYM_W-1:0]   symbol;
        logic [LEN_W-1:0]   length;
        logic [MAX_LEN-1:0] code;
    } entry_t;

    // Mask selecting the low 'len' bits of a MAX_LEN-wide code.
    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            m[i] = (LEN_W'(i) < len);
        end
        return m;
    endfunction

endpackage

// File: rtl/huffman_decoder_if.sv
// Bit-in / symbol-out stream bundle of the Huffman decoder.
//   bit_in, bit_valid, bit_ready : serial MSB-first code bits (valid/ready)
//   sym_out, sym_valid, sym_ready: decoded symbols (valid/ready)
// slave = decoder side, master = producer/consumer side.
interface huffman_decoder_if;

    logic                          bit_in;
    logic                          bit_valid;
    logic                          bit_ready;
    logic [huffman_pkg::SYM_W-1:0] sym_out;
    logic                          sym_valid;
    logic                          sym_ready;

    modport slave (
        input  bit_in, bit_valid, sym_ready,
        output bit_ready, sym_out, sym_valid
    );

    modport master (
        output bit_in, bit_valid, sym_ready,
        input  bit_ready, sym_out, sym_valid
    );

endinterface

// File: rtl/huffman_match_cam.sv
// Parallel compare of the candidate code against every table entry with a
// lowest-index-wins priority encoder. Purely combinational.
//   acc_next   : candidate code, right-aligned
//   cnt_next   : number of valid bits in acc_next
//   entries    : table contents
//   hit        : some valid entry matches
//   hit_symbol : symbol of the lowest-index matching entry
module huffman_match_cam
    import huffman_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES
) (
    input  logic [MAX_LEN-1:0] acc_next,
    input  logic [LEN_W-1:0]   cnt_next,
    input  entry_t             entries [ENTRIES],
    output logic               hit,
    output logic [SYM_W-1:0]   hit_symbol
);

    logic [MAX_LEN-1:0] mask;

    assign mask = len_mask(cnt_next);

    // Scan high to low so the lowest matching index is written last.
    always_comb begin
        hit        = 1'b0;
        hit_symbol = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (entries[i].valid && (entries[i].length == cnt_next) &&
                (((acc_next ^ entries[i].code) & mask) == '0)) begin
                hit        = 1'b1;
                hit_symbol = entries[i].symbol;
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder: loads a {symbol, length, code} table, then decodes a serial
// MSB-first bitstream into symbols.
// Optional macro HUFFMAN_DEC_ERR_EN: invalid code -> sticky err and ERR state.
// Ports:
//   clock, reset_n            : clock, async active-low reset
//   table_we/symbol/length/code, table_done : table load (LOAD state only)
//   table_full                : table capacity reached
//   stream                    : bit-in / symbol-out handshakes (slave modport)
//   state                     : LOAD=0, RUN=1, ERR=2
//   err                       : sticky invalid-code flag
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int unsigned ENTRIES = DEF_ENTRIES
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               table_we,
    input  logic [SYM_W-1:0]   table_symbol,
    input  logic [LEN_W-1:0]   table_length,
    input  logic [MAX_LEN-1:0] table_code,
    input  logic               table_done,
    output logic               table_full,
    huffman_decoder_if.slave   stream,
    output logic [1:0]         state,
    output logic               err
);

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    state_t             state_q, state_d;
    logic [MAX_LEN-2:0] acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic               sym_valid_q, sym_valid_d;
    logic               full_q;
    logic [IDX_W-1:0]   wr_ptr_q;
    entry_t             tbl [ENTRIES];

    logic               we_c;
    logic               len_ok_c;
    logic               bit_ready_c;
    logic               bit_take_c;
    logic [MAX_LEN-1:0] acc_next_c;
    logic [LEN_W-1:0]   cnt_next_c;
    logic               hit_c;
    logic [SYM_W-1:0]   hit_sym_c;

`ifdef HUFFMAN_DEC_ERR_EN
    logic               err_q, err_d;
`endif

    assign len_ok_c    = (table_length != '0) && (table_length <= LEN_W'(MAX_LEN));
    assign bit_ready_c = (state_q == ST_RUN) && !(sym_valid_q && !stream.sym_ready);
    assign bit_take_c  = stream.bit_valid && bit_ready_c;
    assign acc_next_c  = {acc_q, stream.bit_in};
    assign cnt_next_c  = cnt_q + LEN_W'(1);

    huffman_match_cam #(
        .ENTRIES    (ENTRIES)
    ) u_cam (
        .acc_next   (acc_next_c),
        .cnt_next   (cnt_next_c),
        .entries    (tbl),
        .hit        (hit_c),
        .hit_symbol (hit_sym_c)
    );

    // Table storage and write pointer; written only while loading.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl[i] <= '0;
            end
            wr_ptr_q <= '0;
            full_q   <= 1'b0;
        end else if (we_c) begin
            tbl[wr_ptr_q] <= '{valid: 1'b1, symbol: table_symbol,
                               length: table_length, code: table_code};
            wr_ptr_q      <= wr_ptr_q + IDX_W'(1);
            if (wr_ptr_q == IDX_W'(ENTRIES - 1)) begin
                full_q <= 1'b1;
            end
        end
    end

    // State, accumulator and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOAD;
            acc_q       <= '0;
            cnt_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
`ifdef HUFFMAN_DEC_ERR_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
`ifdef HUFFMAN_DEC_ERR_EN
            err_q       <= err_d;
`endif
        end
    end

    // Next-state: table load, bit accumulation, match and symbol handshake.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q && !stream.sym_ready;
        we_c        = 1'b0;
`ifdef HUFFMAN_DEC_ERR_EN
        err_d       = err_q;
`endif
        case (state_q)
            ST_LOAD: begin
                we_c = table_we && len_ok_c && !full_q;
                if (table_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bit_take_c) begin
                    if (hit_c) begin
                        sym_d       = hit_sym_c;
                        sym_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                    end else if (cnt_next_c == LEN_W'(MAX_LEN)) begin
                        // Longest legal code seen without a match.
                        acc_d = '0;
                        cnt_d = '0;
`ifdef HUFFMAN_DEC_ERR_EN
                        state_d = ST_ERR;
                        err_d   = 1'b1;
`endif
                    end else begin
                        acc_d = acc_next_c[MAX_LEN-2:0];
                        cnt_d = cnt_next_c;
                    end
                end
            end
            default: ;
        endcase
    end

    assign stream.bit_ready = bit_ready_c;
    assign stream.sym_out   = sym_q;
    assign stream.sym_valid = sym_valid_q;
    assign table_full       = full_q;
    assign state            = state_q;
`ifdef HUFFMAN_DEC_ERR_EN
    assign err              = err_q;
`else
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: directed scenarios plus randomized
// tables/bitstreams scored against a queue-based reference decoder.
module tb_huffman_decoder;

    logic       clock;
    logic       reset_n;
    logic       table_we;
    logic [7:0] table_symbol;
    logic [3:0] table_length;
    logic [7:0] table_code;
    logic       table_done;
    logic       table_full;
    logic [1:0] state;
    logic       err;

    huffman_decoder_if sif ();

    huffman_decoder dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .table_we     (table_we),
        .table_symbol (table_symbol),
        .table_length (table_length),
        .table_code   (table_code),
        .table_done   (table_done),
        .table_full   (table_full),
        .stream       (sif),
        .state        (state),
        .err          (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: table as parallel queues, pending bits, expected symbols.
    int       m_sym[$];
    int       m_len[$];
    int       m_code[$];
    bit       bits_q[$];
    int       exp_q[$];

    bit       basic_bits[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit       basic_vld[5]   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int       basic_sym[5]   = '{'h41, 0, 'h42, 0, 'h43};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Assert reset mid-cycle, check every output is cleared, then release.
    task automatic apply_reset(input string tag);
        reset_n       = 1'b0;
        table_we      = 1'b0;
        table_done    = 1'b0;
        table_symbol  = '0;
        table_length  = '0;
        table_code    = '0;
        sif.bit_valid = 1'b0;
        sif.bit_in    = 1'b0;
        sif.sym_ready = 1'b1;
        m_sym.delete();
        m_len.delete();
        m_code.delete();
        bits_q.delete();
        exp_q.delete();
        #2;
        check({tag, "_state"}, state, 0);
        check({tag, "_bit_ready"}, sif.bit_ready, 0);
        check({tag, "_sym_valid"}, sif.sym_valid, 0);
        check({tag, "_sym_out"}, sif.sym_out, 0);
        check({tag, "_table_full"}, table_full, 0);
        check({tag, "_err"}, err, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    // One table write; the model applies the length and capacity rules.
    task automatic load(input int s, input int len, input int code);
        if (len >= 1 && len <= 8 && m_sym.size() < 32) begin
            m_sym.push_back(s);
            m_len.push_back(len);
            m_code.push_back(code & ((1 << len) - 1));
        end
        table_we     = 1'b1;
        table_symbol = 8'(s);
        table_length = 4'(len);
        table_code   = 8'(code);
        tick();
        table_we     = 1'b0;
    endtask

    task automatic finish_load();
        table_done = 1'b1;
        tick();
        table_done = 1'b0;
    endtask

    task automatic load_abc();
        load('h41, 1, 0);
        load('h42, 2, 2);
        load('h43, 2, 3);
        finish_load();
    endtask

    task automatic push_code(input int code, input int len);
        for (int b = len - 1; b >= 0; b--) begin
            bits_q.push_back(bit'((code >> b) & 1));
        end
    endtask

    // Decode the pending bitstream from an empty accumulator into exp_q.
    task automatic model_run();
        int acc = 0;
        int cnt = 0;
        foreach (bits_q[k]) begin
            int found = -1;
            acc = acc * 2 + int'(bits_q[k]);
            cnt++;
            for (int i = 0; i < m_sym.size(); i++) begin
                if (m_len[i] == cnt && m_code[i] == acc) begin
                    found = i;
                    break;
                end
            end
            if (found >= 0) begin
                exp_q.push_back(m_sym[found]);
                acc = 0;
                cnt = 0;
            end else if (cnt == 8) begin
                acc = 0;
                cnt = 0;
            end
        end
    endtask

    // Feed bits_q and score every accepted symbol against exp_q.
    task automatic run_stream(input bit rnd, input int budget);
        int n = 0;
        while ((bits_q.size() > 0 || exp_q.size() > 0 || sif.sym_valid) && n < budget) begin
            sif.bit_valid = (bits_q.size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
            sif.bit_in    = (bits_q.size() > 0) ? bits_q[0] : 1'b0;
            sif.sym_ready = !rnd || ($urandom_range(0, 1) == 1);
            #1;
            if (sif.sym_valid && sif.sym_ready) begin
                if (exp_q.size() == 0) check("spurious_sym_valid", sif.sym_valid, 0);
                else check("sym_out", sif.sym_out, exp_q.pop_front());
            end
            if (sif.bit_valid && sif.bit_ready) void'(bits_q.pop_front());
            @(posedge clock);
            #1;
            n++;
        end
        check("stream_left", bits_q.size() + exp_q.size(), 0);
        sif.bit_valid = 1'b0;
        sif.sym_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        #2;

        // Basic decode with exact one-cycle latency.
        apply_reset("rst0");
        load_abc();
        check("state_run", state, 1);
        for (int k = 0; k < 5; k++) begin
            sif.bit_valid = 1'b1;
            sif.bit_in    = basic_bits[k];
            #1;
            check("basic_bit_ready", sif.bit_ready, 1);
            tick();
            check("basic_sym_valid", sif.sym_valid, basic_vld[k]);
            if (basic_vld[k]) check("basic_sym_out", sif.sym_out, basic_sym[k]);
        end
        sif.bit_valid = 1'b0;

        // Backpressure: pending symbol stalls the bit input.
        apply_reset("rst1");
        load_abc();
        sif.sym_ready = 1'b0;
        sif.bit_valid = 1'b1;
        sif.bit_in    = 1'b0;
        tick();
        check("bp_first_valid", sif.sym_valid, 1);
        check("bp_first_sym", sif.sym_out, 'h41);
        sif.bit_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_bit_ready", sif.bit_ready, 0);
            tick();
            check("bp_hold_sym", sif.sym_out, 'h41);
        end
        sif.bit_valid = 1'b0;
        bits_q = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp_q.push_back('h41);
        model_run();
        run_stream(1'b0, 50);

        // Invalid code: eight 1-bits against {A, len 2, code 00}.
        apply_reset("rst2");
        load('h41, 2, 0);
        finish_load();
        for (int k = 0; k < 8; k++) begin
            sif.bit_valid = 1'b1;
            sif.bit_in    = 1'b1;
            #1;
            check("inv_bit_ready", sif.bit_ready, 1);
            tick();
        end
        sif.bit_valid = 1'b0;
        #1;
        check("inv_sym_valid", sif.sym_valid, 0);
`ifdef HUFFMAN_DEC_ERR_EN
        check("inv_err", err, 1);
        check("inv_state", state, 2);
        check("inv_bit_ready_err", sif.bit_ready, 0);
`else
        check("inv_err", err, 0);
        check("inv_state", state, 1);
        bits_q = '{1'b0, 1'b0};
        model_run();
        run_stream(1'b0, 20);
`endif

        // Table edges: zero length, 33 writes, duplicate codes.
        apply_reset("rst3");
        load('h99, 0, 0);
        check("len0_full", table_full, 0);
        load('h10, 3, 5);
        load('h20, 3, 5);
        for (int i = 2; i < 32; i++) begin
            load('h80 + i, 8, i);
            if (i == 30) check("full_at_31", table_full, 0);
        end
        check("full_at_32", table_full, 1);
        load('h77, 1, 0);
        check("full_after_33", table_full, 1);
        finish_load();
        push_code(5, 3);
        push_code(5, 8);
        push_code(31, 8);
        model_run();
        run_stream(1'b0, 60);

        // Randomized tables and streams with random handshakes.
        for (int r = 0; r < 6; r++) begin
            int nsym;
            apply_reset("rst_rnd");
            if (r % 2 == 0) begin
                int len = int'($urandom_range(1, 5));
                for (int c = 0; c < (1 << len); c++) load(int'($urandom_range(0, 255)), len, c);
            end else begin
                for (int k = 0; k < 7; k++) load(int'($urandom_range(0, 255)), k + 1, (1 << (k + 1)) - 2);
                load(int'($urandom_range(0, 255)), 8, 255);
            end
            finish_load();
            nsym = m_sym.size();
            for (int s = 0; s < 40; s++) begin
                int idx = int'($urandom_range(0, nsym - 1));
                push_code(m_code[idx], m_len[idx]);
            end
            model_run();
            run_stream(1'b1, 3000);
        end

        // Reset mid-stream discards the partial code.
        apply_reset("rst4");
        load_abc();
        sif.bit_valid = 1'b1;
        sif.bit_in    = 1'b1;
        tick();
        apply_reset("rst_mid");
        load_abc();
        bits_q = '{1'b1, 1'b0};
        model_run();
        run_stream(1'b0, 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/huffman_decoder.md
# huffman_decoder

Receive-side counterpart of `Huffman_encoder`. It loads the code table the encoder emits (symbol, length, code) into a small associative table. It then accepts a serial MSB-first code bitstream and reproduces the original 8-bit symbol stream, with valid/ready handshakes on both the bit input and the symbol output.

## Interface
Parameters:
- `SYM_W`, 8: symbol width
- `LEN_W`, 4: code-length field width
- `MAX_LEN`, 8: longest legal code, in bits; also the width of the code field
- `ENTRIES`, 32: table capacity

Ports:
- `clock`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `table_we`  in  1  write one table entry (LOAD state only)
- `table_symbol`  in  SYM_W  symbol of the entry
- `table_length`  in  LEN_W  code length, 1..MAX_LEN
- `table_code`  in  MAX_LEN  code, right-aligned; bit `length-1` is sent first
- `table_done`  in  1  table complete; move to RUN
- `table_full`  out  1  ENTRIES entries stored
- `bit_in`  in  1  code bit
- `bit_valid`  in  1  bit_in valid
- `bit_ready`  out  1  decoder accepts the bit this cycle
- `sym_out`  out  SYM_W  decoded symbol
- `sym_valid`  out  1  sym_out valid
- `sym_ready`  in  1  downstream accepts the symbol
- `state`  out  2  LOAD=0, RUN=1, ERR=2
- `err`  out  1  sticky invalid-code flag

## Operation
- **Reset (async, reset_n=0):** all outputs are 0 (`state`=LOAD, `bit_ready`=0, `sym_valid`=0, `table_full`=0, `err`=0). Entry count, accumulator, bit count and all valid bits are cleared. Reset asserted mid-stream discards any partial code and any pending symbol.
- **LOAD:**
  - Each `table_we` writes {symbol, length, code} at the current write pointer, and the pointer increments.
  - Writes with `table_length`=0 or `table_length`>MAX_LEN are ignored.
  - Writes while `table_full`=1 are dropped.
  - `table_done` moves the block to RUN on the next edge. If `table_we` and `table_done` are high in the same cycle, the entry is written first.
- **RUN:**
  - A bit is accepted when `bit_valid && bit_ready`.
  - `acc_next = {acc, bit_in}` and `cnt_next = cnt+1`.
  - The accepted bit is compared in parallel against every valid entry: match when `length==cnt_next` and the low `length` bits of `acc_next` equal the low `length` bits of `code`. The lowest-index match wins.
  - On a match: the symbol is registered to `sym_out`, `sym_valid` is set, and `acc`/`cnt` clear to 0.
  - No match and `cnt_next`<MAX_LEN: keep accumulating.
- **Invalid code:** no match and `cnt_next`==MAX_LEN. Behaviour is set by the macro (see Configuration).
- **Output handshake:**
  - `bit_ready = (state==RUN) && !(sym_valid && !sym_ready)`.
  - `sym_valid` clears on `sym_valid && sym_ready`, unless a new match loads in the same cycle, in which case it stays 1 with the new symbol.
- **Table contents:** the table is never modified in RUN or ERR. Only reset returns the block to LOAD.

## Timing
- Latency: `sym_valid` rises on the edge that accepts the final code bit; the symbol is visible the cycle after the bit is presented.
- Throughput: one bit per cycle. Back-to-back 1-bit codes give one symbol per cycle when `sym_ready`=1.
- `bit_ready` is combinational from `state`, `sym_valid` and `sym_ready`. There is no other input-to-output combinational path.
- `table_full` updates on the edge of the ENTRIES-th write.

## Configuration
- `HUFFMAN_DEC_ERR_EN` defined:
  - An invalid code sets `err`=1 and moves `state` to ERR.
  - In ERR, `bit_ready`=0.
  - A pending symbol still drains.
  - Only reset leaves ERR.
- `HUFFMAN_DEC_ERR_EN` undefined:
  - `err` is tied to 0 and the ERR state does not exist.
  - An invalid code silently clears `acc`/`cnt` and decoding continues in RUN.

## Structure
- Package `huffman_pkg`:
  - SYM_W, LEN_W and MAX_LEN default constants
  - state encoding constants (LOAD/RUN/ERR)
  - a packed entry type {valid, symbol, length, code}, shared with the encoder
- Sub-module `huffman_match_cam`: ENTRIES-wide parallel compare with priority encoder. Inputs: `acc_next`, `cnt_next`, entry array. Outputs: hit and hit_symbol. The top level holds the FSM, table registers, accumulator and handshake.

## Test plan
- **Basic decode:** load A(0x41,len1,code 0), B(0x42,len2,code 10), C(0x43,len2,code 11), then `table_done`; bits 0,1,0,1,1 -> symbols 0x41, 0x42, 0x43, each with `sym_valid` one cycle after its final bit.
- **Backpressure:** same table, `sym_ready`=0 after the first symbol -> `bit_ready` drops; hold 5 cycles, raise `sym_ready` -> 0x42 then 0x43, no loss or duplication.
- **Invalid code:** table {A len2 code 00}, eight 1-bits -> with macro, `err`=1 and `state`=2 after the 8th accepted bit; without macro, no symbol and `state` stays 1.
- **Table edges:** 33 writes with ENTRIES=32 -> `table_full`=1 after the 32nd and the 33rd is dropped; a write with `table_length`=0 is ignored; duplicate codes -> lower index symbol is output.
- **Reset mid-stream:** `reset_n` low after 1 bit of code 10 -> all outputs 0 and `state`=0; reload table, bits 1,0 -> 0x42.
